// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the pipe_chain register chain.
// Holds the default payload width / depth and the occupancy-width function.
package pipe_pkg;

    localparam int PIPE_N_DEF     = 4;
    localparam int PIPE_DEPTH_DEF = 2;

    // Width needed to count 0..depth valid entries.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid+data register of the chain.
// Load copies the incoming valid and, only when that valid is set, the
// incoming payload; flush clears valid only; reset clears valid and data.
module pipe_stage #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_load,
    input  logic         i_valid,
    input  logic [N-1:0] i_data,
    output logic         o_valid,
    output logic [N-1:0] o_data
);

    logic         r_valid;
    logic [N-1:0] r_data;

    // Stage register: reset > flush > load > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage valid/ready register chain with bubble collapsing.
// Optional build macro: PIPE_OCC_EN adds the occupancy output (popcount of
// the stage valid bits); without it the port and its logic are absent.
//
// Handshake: a word moves across an interface on a rising edge when valid
// and ready are both high at that edge; valid never depends on ready, and
// a presented word stays put (no retraction expected) until it is taken.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int N     = PIPE_N_DEF,
    parameter int DEPTH = PIPE_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
`ifdef PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH:0]   w_ready;
    logic [N-1:0]     w_data     [DEPTH];
    logic [DEPTH-1:0] w_src_valid;
    logic [N-1:0]     w_src_data [DEPTH];

    // The consumer terminates the ready chain.
    assign w_ready[DEPTH] = out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        // An empty stage always accepts, so bubbles collapse toward the output.
        assign w_ready[g] = !w_valid[g] || w_ready[g+1];

        if (g == 0) begin : g_head
            assign w_src_valid[g] = in_valid;
            assign w_src_data[g]  = in_data;
        end else begin : g_body
            assign w_src_valid[g] = w_valid[g-1];
            assign w_src_data[g]  = w_data[g-1];
        end

        pipe_stage #(.N(N)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_flush (flush),
            .i_load  (w_ready[g]),
            .i_valid (w_src_valid[g]),
            .i_data  (w_src_data[g]),
            .o_valid (w_valid[g]),
            .o_data  (w_data[g])
        );
    end

    // Words are refused while flushing so nothing is lost silently.
    assign in_ready  = w_ready[0] && !flush;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];

`ifdef PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    // Occupancy is the number of stages currently holding a valid entry.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(w_valid[i]);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: drives DEPTH=1,2,3 chains (N=4) from one shared stimulus and
// checks each against a queue-of-entries model (entry order plus stage index).
module tb_pipe_chain;

    localparam int N  = 4;
    localparam int ND = 3;  // instance d has DEPTH = d+1

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, flush, in_valid, out_ready;
    logic [N-1:0] in_data;
    logic [ND-1:0] o_in_ready, o_out_valid;
    logic [N-1:0]  o_out_data [ND];
`ifdef PIPE_OCC_EN
    logic [1:0]    o_occ [ND];
`endif

    for (genvar g = 0; g < ND; g++) begin : g_dut
`ifdef PIPE_OCC_EN
        logic [$clog2(g+2)-1:0] w_occ;
        assign o_occ[g] = 2'(w_occ);
`endif
        pipe_chain #(.N(N), .DEPTH(g + 1)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (o_in_ready[g]),
            .in_data   (in_data),
            .out_valid (o_out_valid[g]),
            .out_ready (out_ready),
            .out_data  (o_out_data[g])
`ifdef PIPE_OCC_EN
            ,
            .occupancy (w_occ)
`endif
        );
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    bit run_chk = 1'b0;
    bit sb_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instance holds an ordered list of entries (oldest first), each with
    // the stage index it sits in. Every cycle each entry steps one stage
    // forward unless it would land on the entry ahead of it.
    int           m_cnt [ND];
    int           m_pos [ND][3];
    logic [N-1:0] m_dat [ND][3];
    logic [N-1:0] exp_q [$];     // delivery order for the DEPTH=3 instance

    function automatic bit m_out_valid(input int d);
        return (m_cnt[d] > 0) && (m_pos[d][0] == d);
    endfunction

    // Lowest stage index occupied after the coming edge (DEPTH when empty).
    function automatic int m_lim_after(input int d, input bit ordy);
        int lim;
        int start;
        lim   = d + 1;
        start = (m_out_valid(d) && ordy) ? 1 : 0;
        for (int j = start; j < m_cnt[d]; j++) begin
            int np;
            np = m_pos[d][j] + 1;
            if (np > lim - 1) np = lim - 1;
            lim = np;
        end
        return lim;
    endfunction

    function automatic bit m_in_ready(input int d, input bit ordy, input bit fl);
        return (m_lim_after(d, ordy) > 0) && !fl;
    endfunction

    task automatic m_step(input int d, input bit rst, input bit fl, input bit iv,
                          input logic [N-1:0] id, input bit ordy);
        bit acc;
        bit pop;
        int lim;
        if (rst) begin
            m_cnt[d] = 0;
            return;
        end
        acc = iv && m_in_ready(d, ordy, fl);
        pop = m_out_valid(d) && ordy;
        if (pop) begin
            for (int j = 1; j < m_cnt[d]; j++) begin
                m_pos[d][j-1] = m_pos[d][j];
                m_dat[d][j-1] = m_dat[d][j];
            end
            m_cnt[d]--;
        end
        lim = d + 1;
        for (int j = 0; j < m_cnt[d]; j++) begin
            int np;
            np = m_pos[d][j] + 1;
            if (np > lim - 1) np = lim - 1;
            m_pos[d][j] = np;
            lim = np;
        end
        if (fl) begin
            m_cnt[d] = 0;
        end else if (acc) begin
            m_pos[d][m_cnt[d]] = 0;
            m_dat[d][m_cnt[d]] = id;
            m_cnt[d]++;
        end
    endtask

    // Model advances on every rising edge with the inputs present at that edge.
    always @(posedge clk) begin
        if (run_chk) begin
            sb_acc = in_valid && m_in_ready(2, out_ready, flush);
            if (reset || flush) exp_q.delete();
            else if (sb_acc) exp_q.push_back(in_data);
            for (int d = 0; d < ND; d++) begin
                m_step(d, reset, flush, in_valid, in_data, out_ready);
            end
        end
    end

    // Compare process: all DUT outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (run_chk) begin
            for (int d = 0; d < ND; d++) begin
                check($sformatf("in_ready_d%0d", d + 1), o_in_ready[d], m_in_ready(d, out_ready, flush));
                check($sformatf("out_valid_d%0d", d + 1), o_out_valid[d], m_out_valid(d));
                if (m_out_valid(d)) begin
                    check($sformatf("out_data_d%0d", d + 1), o_out_data[d], m_dat[d][0]);
                end
`ifdef PIPE_OCC_EN
                check($sformatf("occupancy_d%0d", d + 1), o_occ[d], m_cnt[d]);
`endif
            end
            if (o_out_valid[2] && out_ready) begin
                if (exp_q.size() > 0) check("sb_order_d3", o_out_data[2], exp_q.pop_front());
                else check("sb_spurious_d3", o_out_valid[2], 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit iv, input logic [N-1:0] id, input bit ordy,
                         input bit fl, input bit rst);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive(0, '0, 0, 0, 1);
        repeat (2) edge_step();
        run_chk = 1'b1;

        // reset state
        mid();
        for (int d = 0; d < ND; d++) begin
            check("rst_out_valid", o_out_valid[d], 0);
            check("rst_out_data", o_out_data[d], 0);
            check("rst_in_ready", o_in_ready[d], 1);
        end
        edge_step();
        drive(0, '0, 0, 0, 0);

        // latency: words 1..6 at 10-cycle spacing, out_ready high
        for (int v = 1; v <= 6; v++) begin
            drive(1, 4'(v), 1, 0, 0);
            edge_step();
            drive(0, 4'(v), 1, 0, 0);
            edge_step();
            mid();
            check("lat_valid_d2", o_out_valid[1], 1);
            check("lat_data_d2", o_out_data[1], v);
            check("lat_early_d3", o_out_valid[2], 0);
            repeat (8) edge_step();
        end

        // full chain stalled, then drained in order
        drive(0, '0, 0, 0, 1);
        edge_step();
        for (int v = 7; v <= 9; v++) begin
            drive(1, 4'(v), 0, 0, 0);
            edge_step();
        end
        drive(1, 4'd10, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            mid();
            check("full_in_ready_d3", o_in_ready[2], 0);
            check("full_hold_data_d3", o_out_data[2], 7);
            edge_step();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, '0, 1, 0, 0);
            mid();
            check("drain_valid_d3", o_out_valid[2], 1);
            check("drain_data_d3", o_out_data[2], 7 + k);
            edge_step();
        end
        mid();
        check("drained_d3", o_out_valid[2], 0);

        // bubble collapse behind a stalled head
        drive(0, '0, 0, 0, 1);
        edge_step();
        drive(1, 4'd11, 0, 0, 0);
        edge_step();
        drive(0, '0, 0, 0, 0);
        repeat (2) edge_step();
        mid();
        check("bubble_in_ready_d3", o_in_ready[2], 1);
        check("bubble_head_d3", o_out_data[2], 11);
        drive(1, 4'd12, 0, 0, 0);
        edge_step();
        drive(1, 4'd13, 0, 0, 0);
        edge_step();
        drive(0, '0, 0, 0, 0);
        mid();
        check("collapsed_full_d3", o_in_ready[2], 0);
        check("collapsed_head_d3", o_out_data[2], 11);

        // flush of a full chain
        drive(1, 4'd14, 0, 1, 0);
        mid();
        for (int d = 0; d < ND; d++) check("flush_in_ready", o_in_ready[d], 0);
        edge_step();
        drive(0, '0, 0, 0, 0);
        mid();
        for (int d = 0; d < ND; d++) check("post_flush_valid", o_out_valid[d], 0);
        check("post_flush_ready_d3", o_in_ready[2], 1);

        // reset with entries in flight, then a fresh word
        edge_step();
        drive(1, 4'd1, 0, 0, 0);
        edge_step();
        drive(1, 4'd2, 0, 0, 0);
        edge_step();
        drive(1, 4'd3, 1, 0, 1);
        edge_step();
        drive(0, '0, 1, 0, 0);
        mid();
        for (int d = 0; d < ND; d++) begin
            check("midrst_valid", o_out_valid[d], 0);
            check("midrst_data", o_out_data[d], 0);
        end
        drive(1, 4'd5, 1, 0, 0);
        edge_step();
        drive(0, '0, 1, 0, 0);
        edge_step();
        mid();
        check("w5_not_yet_d3", o_out_valid[2], 0);
        edge_step();
        mid();
        check("w5_valid_d3", o_out_valid[2], 1);
        check("w5_data_d3", o_out_data[2], 5);
        edge_step();

        // randomized traffic with varying consumer back-pressure
        for (int w = 0; w < 15; w++) begin
            int pct;
            pct = $urandom_range(0, 100);
            for (int c = 0; c < 200; c++) begin
                drive($urandom_range(0, 3) != 0,
                      4'($urandom_range(0, 15)),
                      $urandom_range(0, 99) < pct,
                      $urandom_range(0, 39) == 0,
                      $urandom_range(0, 199) == 0);
                edge_step();
            end
        end

        drive(0, '0, 1, 0, 0);
        repeat (5) edge_step();
        run_chk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 Parameter N, default 4: payload width in bits, N >= 1.
REQ-002 Parameter DEPTH, default 2: number of register stages, DEPTH >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all in-flight entries.
REQ-006 in_valid  input  1  producer presents in_data.
REQ-007 in_ready  output  1  chain accepts in_data this cycle.
REQ-008 in_data  input  N  input payload.
REQ-009 out_valid  output  1  last stage holds a valid entry.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_data  output  N  last-stage payload.
REQ-012 occupancy  output  $clog2(DEPTH+1)  valid entries held; present only with PIPE_OCC_EN.

Function
REQ-013 Stage i (0..DEPTH-1) SHALL hold data_i[N] and valid_i; stage 0 fed by input, stage DEPTH-1 drives out_data/out_valid.
REQ-014 ready_i SHALL equal !valid_i || ready_(i+1), with ready_DEPTH = out_ready (bubble collapsing: empty stage always accepts).
REQ-015 in_ready SHALL equal ready_0 && !flush.
REQ-016 Transfer at stage i when ready_i: valid_i <= incoming valid; data_i <= incoming data only if incoming valid, else data_i holds.
REQ-017 When !ready_i, stage i SHALL hold data_i and valid_i unchanged.
REQ-018 Latency: word accepted at edge k SHALL appear on out_data with out_valid after edge k+DEPTH-1 when unstalled (i.e., visible DEPTH cycles after in_valid presented).
REQ-019 Throughput: one word per cycle with out_ready held high; no word dropped or duplicated under any out_ready pattern.
REQ-020 Full: all valid_i set and out_ready low -> in_ready low; words presented then not captured.
REQ-021 Simultaneous in_valid and out_ready when full SHALL shift the whole chain and accept the new word in the same cycle.
REQ-022 flush SHALL clear every valid_i at the next edge, overriding any transfer; data registers may keep stale values; an out_valid&&out_ready handshake in the flush cycle still counts as delivered.
REQ-023 DEPTH=1 SHALL behave as a single registered stage with the same rules.

Reset
REQ-024 reset SHALL clear all valid_i and all data_i to 0 at the next edge; out_valid=0, out_data=0, occupancy=0 after.
REQ-025 reset SHALL have priority over flush and transfers; reset mid-stream discards all entries.
REQ-026 in_ready SHALL be combinationally valid during reset (value 1 unless flush); words accepted while reset is high are discarded.

Configuration
REQ-027 Macro PIPE_OCC_EN defined: occupancy port exists and equals popcount of valid_i registers.
REQ-028 PIPE_OCC_EN undefined: occupancy port and its logic absent; all other behaviour identical.

Structure
REQ-029 Shared package pipe_pkg SHALL hold the occupancy-width function (clog2(DEPTH+1)) and default parameter constants.
REQ-030 One sub-module pipe_stage (one valid+data register with load/hold/clear) SHALL be instantiated DEPTH times in a generate loop.

Verification
REQ-031 DEPTH=2, N=4, out_ready=1, in_data 1..6 at 10-cycle intervals -> each value on out_data 2 cycles after presentation, no gaps missing.
REQ-032 DEPTH=3, fill with 7,8,9, out_ready=0 -> in_ready=0, out_data=7 held; raise out_ready 3 cycles -> outputs 7,8,9 in order.
REQ-033 DEPTH=3, stage 2 valid stalled, stages 0-1 empty -> in_ready=1, two words collapse into stages 1 and 0 while stalled.
REQ-034 Full chain, assert flush one cycle -> out_valid=0 next cycle, occupancy=0, in_ready=0 during flush cycle.
REQ-035 Reset asserted with 2 entries in flight -> out_valid=0, out_data=0 next cycle; post-reset word 5 emerges after DEPTH cycles.
REQ-036 PIPE_OCC_EN build: random valid/ready traffic -> occupancy equals scoreboard count every cycle.
